fir_out_serializer: RTL
=======================

# fir_out_serializer

Output-side serializer for the 3-parallel unfolded FIR. Accepts one triplet of filtered samples (DOUT, DOUT_2, DOUT_3 of the filter) per valid cycle. Buffers triplets in a small FIFO and emits them one sample per clock, in order, on a valid/ready stream. It sits between the filter and any single-rate consumer, such as a serial sink or a DAC interface.

## Interface
- WIDTH, 8, sample width in bits (two's complement, passed through unmodified)
- DEPTH, 4, triplet FIFO depth in entries; power of two, ≥ 2
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- DIN  in  WIDTH  parallel sample 0, oldest in time
- DIN_2  in  WIDTH  parallel sample 1
- DIN_3  in  WIDTH  parallel sample 2, newest
- VIN  in  1  triplet valid; driven by the filter's VOUT
- FULL  out  1  FIFO holds DEPTH triplets; upstream stalls its VIN on this
- DOUT  out  WIDTH  serial sample
- VOUT  out  1  DOUT valid
- RDY  in  1  downstream ready
- OVF  out  1  sticky overflow flag (see Configuration)

## Operation
- FIFO entry = {DIN, DIN_2, DIN_3}, 3·WIDTH bits. Write and read pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
- Write: when VIN=1, the entry is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the triplet is dropped: pointers and count are unchanged and OVF is set.
- Output register (DOUT, VOUT) loads when (VOUT=0 or RDY=1) and count>0. Otherwise it holds.
- Phase counter selects the lane of the head entry. Each load advances the phase 0→1→2→0:
  - 0 loads DIN
  - 1 loads DIN_2
  - 2 loads DIN_3; this load also pops the entry
- Phase encodings: S0=0, S1=1, S2=2. Value 3 is unreachable and recovers to S0.
- If (VOUT=1 and RDY=1) and count=0, then VOUT←0 and DOUT holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. This holds at count=DEPTH and at count=1.
- FULL = (count==DEPTH), registered together with the count.
- Transfer rule: a sample is transferred when VOUT=1 and RDY=1. DOUT and VOUT are stable while VOUT=1 and RDY=0.

## Timing
- Reset values: DOUT=0, VOUT=0, FULL=0, OVF=0, count=0, pointers=0, phase=S0. FIFO storage is not reset.
- Reset assertion clears all outputs immediately (asynchronous). Any in-flight triplet is discarded.
- Latency: VIN sampled at edge n with an empty FIFO gives VOUT=1 with DIN's value after edge n+1. DIN_2 follows after edge n+2 and DIN_3 after edge n+3, provided RDY=1.
- Throughput: one sample per cycle. With VIN at most one cycle in three and RDY held at 1, output is gapless and the FIFO never fills.
- FULL rises on the edge that writes the DEPTH-th entry. It falls on the edge that pops while no push occurs.

## Configuration
- FIR_SER_OVF_EN defined: OVF is a sticky register. It is set on any dropped triplet and cleared only by RST.
- FIR_SER_OVF_EN undefined: OVF is tied to 0 and no overflow logic is synthesized. Dropping behaviour is unchanged.

## Structure
- Shared package fir_pkg contains:
  - the default sample width constant (8)
  - the 3-lane count constant (3)
  - the phase typedef (S0, S1, S2)
  - the triplet entry typedef
- One sub-module, fir_triplet_fifo, holds the storage, pointers, count and FULL, and exposes push/pop/empty/head.
- The top level holds the phase FSM, the output register and OVF.

## Test plan
- Single triplet: VIN=1 for one cycle with DIN=10, DIN_2=20, DIN_3=30 and RDY=1 → VOUT high for 3 cycles with DOUT=10, 20, 30, starting one cycle after the VIN edge; VOUT=0 afterwards.
- Rate-matched stream: VIN every third cycle, triplets (1,2,3), (4,5,6), (7,8,9), RDY=1 → DOUT 1..9 on consecutive cycles with no VOUT gap; FULL stays 0.
- Backpressure: RDY=0 while DOUT=20 for 4 cycles → DOUT holds 20 and VOUT=1 throughout; 30 follows one cycle after RDY returns to 1.
- Overflow, DEPTH=4: VIN for 5 consecutive cycles with RDY=0 and the first sample not yet loaded → FULL=1 after the 4th edge; the 5th triplet is dropped; OVF=1 with the macro defined, 0 without it. Draining afterwards yields exactly 12 samples, in order.
- Full with pop: FIFO at 4 entries and DOUT on lane S2 with RDY=1, plus VIN=1 in the same cycle → triplet accepted, FULL stays 1, no OVF.
- Reset mid-triplet: assert RST while DOUT=20 → VOUT=0 and DOUT=0 immediately. After release, with no VIN, VOUT stays 0; the next triplet restarts at lane S0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output serializer.
package fir_pkg;

  // Default sample width in bits.
  localparam int unsigned SampleW = 8;

  // Number of parallel lanes delivered by the unfolded filter.
  localparam int unsigned Lanes = 3;

  // Lane selector for the head entry. Encoding 3 is unused.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } phase_e;

  // One FIFO entry at the default width; lane 0 is the oldest sample.
  typedef logic [Lanes-1:0][SampleW-1:0] triplet_t;

endpackage

// File: rtl/fir_triplet_fifo.sv
// Triplet FIFO: storage, wrap-around pointers, occupancy count and registered full flag.
// The caller only pushes when there is room (or a pop happens in the same cycle)
// and only pops when the FIFO is not empty.
module fir_triplet_fifo
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = SampleW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [Lanes-1:0][WIDTH-1:0] data_i,
  output logic [Lanes-1:0][WIDTH-1:0] head_o,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [Lanes-1:0][WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;

  // Pointer, count and full-flag next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(DEPTH));
  end

  // Control state; storage below is intentionally not reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;

endmodule

// File: rtl/fir_out_serializer.sv
// Serializes 3-lane filter output triplets into a single-sample valid/ready stream.
// Optional feature macro: FIR_SER_OVF_EN enables the sticky overflow flag on OVF;
// without it OVF is tied low (dropping behaviour is the same either way).
module fir_out_serializer
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = SampleW,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] DIN_2,
  input  logic [WIDTH-1:0] DIN_3,
  input  logic             VIN,
  output logic             FULL,
  output logic [WIDTH-1:0] DOUT,
  output logic             VOUT,
  input  logic             RDY,
  output logic             OVF
);

  logic [Lanes-1:0][WIDTH-1:0] wr_data;
  logic [Lanes-1:0][WIDTH-1:0] head;
  logic                        empty;
  logic                        full;
  logic                        push;
  logic                        pop;
  logic                        load;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vout_q, vout_d;
  phase_e           phase_q, phase_d;

  // Lane 0 carries the oldest sample.
  assign wr_data = {DIN_3, DIN_2, DIN};

  // Output register takes a new sample when it is empty or being consumed.
  assign load = (!vout_q || RDY) && !empty;
  // Last lane of the head entry retires the entry.
  assign pop  = load && (phase_q == S2);
  // A full FIFO still accepts when the head is retired in the same cycle.
  assign push = VIN && (!full || pop);

  fir_triplet_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_data),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full)
  );

  // Phase FSM and output register next state.
  always_comb begin
    dout_d  = dout_q;
    vout_d  = vout_q;
    phase_d = phase_q;
    if (load) begin
      vout_d = 1'b1;
      case (phase_q)
        S0: begin
          dout_d  = head[0];
          phase_d = S1;
        end
        S1: begin
          dout_d  = head[1];
          phase_d = S2;
        end
        S2: begin
          dout_d  = head[2];
          phase_d = S0;
        end
        // Unreachable encoding behaves as S0.
        default: begin
          dout_d  = head[0];
          phase_d = S1;
        end
      endcase
    end else if (vout_q && RDY) begin
      // Last sample consumed with nothing queued; DOUT keeps its value.
      vout_d = 1'b0;
    end
  end

  // Phase and output register state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q  <= '0;
      vout_q  <= 1'b0;
      phase_q <= S0;
    end else begin
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      phase_q <= phase_d;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign FULL = full;

`ifdef FIR_SER_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky flag: set on any dropped triplet, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (VIN & !push);
  end

  // Overflow flag register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

endmodule
